// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
//
// Responder end of the CPU port bus (pst/pld). Decodes a 16-bit port address
// and provides an 8N1 UART transmitter fed by a TX FIFO, a GPIO output latch,
// a synchronized GPIO input, a programmable baud divisor and a free-running
// tick counter.
//
// Address map:
//   0x0000 TX_DATA   W: push data[7:0] (dropped when full)   R: 0
//   0x0001 STATUS    R: {count[14:8], ovf[3], busy[2], empty[1], full[0]}
//   0x0002 BAUD_DIV  R/W, clk cycles per bit (0 behaves as 1)
//   0x0003 GPIO_OUT  R/W, low GPIO_W bits
//   0x0004 GPIO_IN   R: synchronized gpio_in, zero-extended
//   0x0005 TICK      R: free-running 16-bit cycle counter
//
// Optional feature (macro IO_OVF_FLAG_EN):
//   STATUS bit3 is a sticky overflow flag, set when a TX_DATA write finds the
//   FIFO full with no same-cycle pop; any committed STATUS write clears it.
//   Without the macro bit3 reads 0 and STATUS writes are ignored.
//
// Ports:
//   clk        system clock, rising edge
//   async_rst  asynchronous active-high reset
//   addr       port address from the CPU
//   data       write data from the CPU
//   write      write level (1 = write, 0 = read)
//   data_out   registered read data (1-cycle latency)
//   tx         serial output, idle high
//   gpio_out   GPIO output latch
//   gpio_in    asynchronous GPIO inputs
// -----------------------------------------------------------------------------
module io_responder #(
    parameter int          FIFO_DEPTH   = 8,
    parameter int          GPIO_W       = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic [15:0]       addr,
    input  logic [15:0]       data,
    input  logic              write,
    output logic [15:0]       data_out,
    output logic              tx,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    localparam logic [15:0] A_TX       = 16'h0000;
    localparam logic [15:0] A_STATUS   = 16'h0001;
    localparam logic [15:0] A_BAUD     = 16'h0002;
    localparam logic [15:0] A_GPIO_OUT = 16'h0003;
    localparam logic [15:0] A_GPIO_IN  = 16'h0004;
    localparam logic [15:0] A_TICK     = 16'h0005;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // ------------------------------------------------------------------
    // Write commit detection. The CPU holds write high between port ops,
    // so a write is new only on a rising write level or when the address
    // or data changed since the previous cycle.
    // ------------------------------------------------------------------
    logic        write_prev_reg;
    logic [15:0] addr_prev_reg;
    logic [15:0] data_prev_reg;
    logic        commit;
    logic        wr_tx;
    logic        wr_baud;
    logic        wr_gpio;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            write_prev_reg <= 1'b0;
            addr_prev_reg  <= '0;
            data_prev_reg  <= '0;
        end else begin
            write_prev_reg <= write;
            addr_prev_reg  <= addr;
            data_prev_reg  <= data;
        end
    end

    assign commit  = write & (~write_prev_reg | (addr != addr_prev_reg) | (data != data_prev_reg));
    assign wr_tx   = commit && (addr == A_TX);
    assign wr_baud = commit && (addr == A_BAUD);
    assign wr_gpio = commit && (addr == A_GPIO_OUT);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [15:0]       baud_reg;
    logic [GPIO_W-1:0] gpio_reg;
    logic [15:0]       tick_reg;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            baud_reg <= BAUD_DIV_RST;
            gpio_reg <= '0;
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + 16'd1;
            if (wr_baud) begin
                baud_reg <= data;
            end
            if (wr_gpio) begin
                gpio_reg <= data[GPIO_W-1:0];
            end
        end
    end

    assign gpio_out = gpio_reg;

    // ------------------------------------------------------------------
    // GPIO input synchronizer, two flops per bit
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] gpio_sync;

    generate
        for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= gpio_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign gpio_sync[gi] = s2_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // TX FIFO: circular buffer with one extra pointer bit to tell full
    // from empty.
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                        (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = wr_tx && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= data[7:0];
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t   state_reg, state_next;
    logic [15:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic        tx_reg, tx_next;
    logic [7:0]  shift_reg;
    logic        shift_en;
    logic [15:0] div_load;

    // Reloaded at every bit boundary, so a new divisor applies from the
    // next bit onward. A divisor of 0 behaves as 1.
    assign div_load = (baud_reg == 16'd0) ? 16'd0 : (baud_reg - 16'd1);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
        end
    end

    // Shift register doubles as the registered FIFO read port; its content
    // is only observed after a pop, so it needs no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_reg <= mem[rd_ptr_reg[IDX_W-1:0]];
        end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        shift_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    state_next   = START;
                    bit_cnt_next = div_load;
                    tx_next      = 1'b0;
                end
            end
            START: begin
                if (bit_cnt_reg == 16'd0) begin
                    state_next   = DATA;
                    bit_cnt_next = div_load;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt_reg == 16'd0) begin
                    bit_cnt_next = div_load;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_en     = 1'b1;
                        // Next bit is the one about to shift into position 0.
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt_reg == 16'd0) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx = tx_reg;

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
`ifdef IO_OVF_FLAG_EN
    logic wr_status;
    logic ovf_reg;

    assign wr_status = commit && (addr == A_STATUS);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            ovf_reg <= 1'b0;
        end else if (wr_status) begin
            ovf_reg <= 1'b0;
        end else if (wr_tx && fifo_full && !pop) begin
            ovf_reg <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path: sampled every cycle from pre-write state
    // ------------------------------------------------------------------
    logic [15:0] rd_mux;
    logic [15:0] data_out_reg;

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_STATUS: begin
                rd_mux[0]         = fifo_full;
                rd_mux[1]         = fifo_empty;
                rd_mux[2]         = (state_reg != IDLE);
`ifdef IO_OVF_FLAG_EN
                rd_mux[3]         = ovf_reg;
`endif
                rd_mux[8 +: PTR_W] = fifo_count;
            end
            A_BAUD:     rd_mux = baud_reg;
            A_GPIO_OUT: rd_mux[GPIO_W-1:0] = gpio_reg;
            A_GPIO_IN:  rd_mux[GPIO_W-1:0] = gpio_sync;
            A_TICK:     rd_mux = tick_reg;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            data_out_reg <= '0;
        end else begin
            data_out_reg <= rd_mux;
        end
    end

    assign data_out = data_out_reg;

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
//
// Self-checking bench for io_responder. Table-driven register vectors,
// hand-written sequences for the multi-cycle corners, and randomized frames
// and register operations checked against a behavioural model: expected tx
// waveforms are built from the 8N1 framing rules (start, 8 data LSB first,
// stop, div cycles per bit), register state is tracked in plain variables.
// -----------------------------------------------------------------------------
module tb_io_responder;

    logic        clk = 1'b0;
    logic        async_rst;
    logic [15:0] addr;
    logic [15:0] data;
    logic        write;
    logic [15:0] data_out;
    logic        tx;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;

    always #5 clk = ~clk;

    io_responder dut (
        .clk      (clk),
        .async_rst(async_rst),
        .addr     (addr),
        .data     (data),
        .write    (write),
        .data_out (data_out),
        .tx       (tx),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

`ifdef IO_OVF_FLAG_EN
    localparam logic [15:0] OVF_BIT = 16'h0008;
`else
    localparam logic [15:0] OVF_BIT = 16'h0000;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic cap_q[$];
    bit   cap_en   = 1'b0;

    logic [15:0] gpio_model;
    logic [15:0] baud_model;

    typedef struct {
        bit          is_wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vt [NVEC];

    // ------------------------------------------------------------------
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%04h expected=0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cap_en) cap_q.push_back(tx);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        data  = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] v);
        write = 1'b0;
        addr  = a;
        tick();
        v = data_out;
    endtask

    // 8N1 frame: start low, data LSB first, stop high; d samples per bit.
    function automatic void add_frame(input logic [7:0] b, input int d);
        for (int i = 0; i < 10 * d; i++) begin
            int   slot;
            logic bv;
            slot = i / d;
            if (slot == 0)      bv = 1'b0;
            else if (slot == 9) bv = 1'b1;
            else                bv = b[slot-1];
            exp_q.push_back(bv);
        end
    endfunction

    task automatic compare_stream(input string name);
        int bad;
        bad = -1;
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            bad = 0;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
            end
        end
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: tx stream differs at sample %0d (got=%0d expected=%0d, len %0d/%0d)",
                     name, bad, (bad < cap_q.size()) ? cap_q[bad] : 1'bx, exp_q[bad],
                     cap_q.size(), exp_q.size());
        end else begin
            $display("ok   %s: %0d tx samples match", name, exp_q.size());
        end
    endtask

    task automatic rand_op(input int n);
        logic [15:0] v, v2, r, a;
        int op;
        op = $urandom_range(0, 4);
        case (op)
            0: begin
                r = 16'($urandom);
                do_write(16'h0003, r);
                gpio_model = r;
                check16($sformatf("rnd%0d gpio_out pin", n), gpio_out, gpio_model);
                do_read(16'h0003, v);
                check16($sformatf("rnd%0d gpio_out rd", n), v, gpio_model);
            end
            1: begin
                r = 16'($urandom);
                gpio_in = r;
                tick();
                tick();
                do_read(16'h0004, v);
                check16($sformatf("rnd%0d gpio_in rd", n), v, r);
            end
            2: begin
                a = 16'($urandom_range(6, 65535));
                do_write(a, 16'($urandom));
                do_read(a, v);
                check16($sformatf("rnd%0d unmapped %04h", n, a), v, 16'h0000);
            end
            3: begin
                do_read(16'h0005, v);
                do_read(16'h0005, v2);
                r = v2 - v;
                check16($sformatf("rnd%0d tick step", n), r, 16'h0001);
            end
            default: begin
                do_read(16'h0001, v);
                check16($sformatf("rnd%0d status idle", n), v, 16'h0002);
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v, v1, v2;
        int          tx_err, busy_err;
        logic        exp_tx, exp_busy;
        logic [7:0]  b;
        int          dw, eff;

        vt[0]  = '{1'b1, 16'h0003, 16'h1234, 16'h0000};
        vt[1]  = '{1'b0, 16'h0003, 16'h0000, 16'h1234};
        vt[2]  = '{1'b1, 16'h0002, 16'h0007, 16'h0000};
        vt[3]  = '{1'b0, 16'h0002, 16'h0000, 16'h0007};
        vt[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
        vt[5]  = '{1'b1, 16'h0004, 16'hFFFF, 16'h0000};
        vt[6]  = '{1'b0, 16'h0004, 16'h0000, 16'hA5A5};
        vt[7]  = '{1'b1, 16'h7777, 16'hBEEF, 16'h0000};
        vt[8]  = '{1'b0, 16'h7777, 16'h0000, 16'h0000};
        vt[9]  = '{1'b0, 16'h0006, 16'h0000, 16'h0000};
        vt[10] = '{1'b1, 16'h0003, 16'hFFFF, 16'h0000};
        vt[11] = '{1'b0, 16'h0003, 16'h0000, 16'hFFFF};
        vt[12] = '{1'b1, 16'h0003, 16'h0000, 16'h0000};
        vt[13] = '{1'b0, 16'h0003, 16'h0000, 16'h0000};
        vt[14] = '{1'b0, 16'h0001, 16'h0000, 16'h0002};
        vt[15] = '{1'b1, 16'h0002, 16'h0364, 16'h0000};
        vt[16] = '{1'b0, 16'h0002, 16'h0000, 16'h0364};
        vt[17] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000};

        // ---------------- reset and input synchronizer ----------------
        async_rst = 1'b1;
        addr      = 16'h0000;
        data      = 16'h0000;
        write     = 1'b0;
        gpio_in   = 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        check16("reset data_out", data_out, 16'h0000);
        check16("reset tx", {15'd0, tx}, 16'h0001);
        check16("reset gpio_out", gpio_out, 16'h0000);
        async_rst = 1'b0;
        addr      = 16'h0004;
        tick();
        tick();
        check16("gpio_in 2 cycles", data_out, 16'h0000);
        tick();
        check16("gpio_in 3 cycles", data_out, 16'hA5A5);
        do_read(16'h0001, v);
        check16("status after reset", v, 16'h0002);

        // ---------------- table vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            if (vt[i].is_wr) begin
                do_write(vt[i].a, vt[i].d);
            end else begin
                do_read(vt[i].a, v);
                check16($sformatf("vec%0d rd %04h", i, vt[i].a), v, vt[i].exp);
            end
        end
        gpio_model = 16'h0000;
        baud_model = 16'h0364;

        // ---------------- 0x55 at divisor 4 with busy ----------------
        do_write(16'h0002, 16'h0004);
        do_write(16'h0000, 16'h0055);
        addr     = 16'h0001;
        tx_err   = 0;
        busy_err = 0;
        b        = 8'h55;
        for (int i = 1; i <= 42; i++) begin
            tick();
            if (i <= 4)       exp_tx = 1'b0;
            else if (i <= 36) exp_tx = b[(i - 5) / 4];
            else              exp_tx = 1'b1;
            exp_busy = (i >= 2 && i <= 41);
            if (tx !== exp_tx) tx_err++;
            if (data_out[2] !== exp_busy) busy_err++;
        end
        check16("frame 0x55 tx errors", 16'(tx_err), 16'd0);
        check16("frame 0x55 busy errors", 16'(busy_err), 16'd0);

        // ---------------- random frames and register ops ----------------
        for (int n = 0; n < 6; n++) begin
            dw  = $urandom_range(0, 6);
            eff = (dw == 0) ? 1 : dw;
            b   = 8'($urandom);
            do_write(16'h0002, 16'(dw));
            baud_model = 16'(dw);
            exp_q.delete();
            cap_q.delete();
            exp_q.push_back(1'b1);
            add_frame(b, eff);
            exp_q.push_back(1'b1);
            cap_en = 1'b1;
            do_write(16'h0000, {8'($urandom), b});
            while (cap_q.size() < exp_q.size()) tick();
            cap_en = 1'b0;
            compare_stream($sformatf("rnd frame %02h div %0d", b, dw));
            repeat (3) rand_op(n);
        end
        do_read(16'h0002, v);
        check16("baud readback", v, baud_model);

        // ---------------- held write merges ----------------
        addr  = 16'h0003;
        data  = 16'h00FF;
        write = 1'b1;
        tick();
        check16("hold gpio first", gpio_out, 16'h00FF);
        repeat (9) tick();
        check16("hold gpio steady", gpio_out, 16'h00FF);
        data = 16'h0F0F;
        tick();
        check16("hold gpio change", gpio_out, 16'h0F0F);
        repeat (3) tick();
        write = 1'b0;

        // ---------------- tick counter and unmapped ----------------
        do_read(16'h0005, v1);
        repeat (99) tick();
        do_read(16'h0005, v2);
        v = v2 - v1;
        check16("tick 100 apart", v, 16'd100);
        do_read(16'h7777, v);
        check16("read 0x7777", v, 16'h0000);

        // ---------------- fill at divisor 3: back-to-back frames ----------------
        do_write(16'h0002, 16'h0003);
        exp_q.delete();
        cap_q.delete();
        exp_q.push_back(1'b1);
        for (int k = 1; k <= 9; k++) begin
            add_frame(8'(k), 3);
            exp_q.push_back(1'b1);
        end
        repeat (30) exp_q.push_back(1'b1);   // 0x0A must never appear
        cap_en = 1'b1;
        addr   = 16'h0000;
        write  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            data = 16'(k);
            tick();
        end
        write = 1'b0;
        while (cap_q.size() < exp_q.size()) tick();
        cap_en = 1'b0;
        compare_stream("fill stream 01..09");

        // ---------------- stalled transmitter: merge, full, overflow ----------------
        do_write(16'h0002, 16'hFFFF);
        addr  = 16'h0000;
        data  = 16'h0001;
        write = 1'b1;
        repeat (10) tick();
        write = 1'b0;
        do_read(16'h0001, v);
        check16("status one commit popped", v, 16'h0006);
        addr  = 16'h0000;
        data  = 16'h0002;
        write = 1'b1;
        repeat (10) tick();
        write = 1'b0;
        do_read(16'h0001, v);
        check16("status one commit queued", v, 16'h0104);
        addr  = 16'h0000;
        write = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            data = 16'(k);
            tick();
        end
        write = 1'b0;
        do_read(16'h0001, v);
        check16("status full", v, 16'h0805 | OVF_BIT);
        do_read(16'h0001, v);
        check16("status full again", v, 16'h0805 | OVF_BIT);
        do_write(16'h0001, 16'h1234);
        do_read(16'h0001, v);
        check16("status after status write", v, 16'h0805);

        // ---------------- async reset during start bit ----------------
        check16("tx in start bit", {15'd0, tx}, 16'h0000);
        #2;
        async_rst = 1'b1;
        #1;
        check16("tx on async reset", {15'd0, tx}, 16'h0001);
        check16("gpio_out on async reset", gpio_out, 16'h0000);
        check16("data_out on async reset", data_out, 16'h0000);
        tick();
        tick();
        async_rst = 1'b0;
        do_read(16'h0001, v);
        check16("status after reset 2", v, 16'h0002);
        do_read(16'h0002, v);
        check16("baud after reset 2", v, 16'h0364);

        // ---------------- async reset mid data bit ----------------
        do_write(16'h0002, 16'h0008);
        do_write(16'h0000, 16'h0000);
        repeat (20) tick();
        check16("tx in data bit", {15'd0, tx}, 16'h0000);
        #2;
        async_rst = 1'b1;
        #1;
        check16("tx on async reset mid data", {15'd0, tx}, 16'h0001);
        tick();
        tick();
        async_rst = 1'b0;
        do_read(16'h0005, v);
        check16("tick restarts", v, 16'h0000);
        do_read(16'h0001, v);
        check16("status after reset 3", v, 16'h0002);
        do_read(16'h0002, v);
        check16("baud after reset 3", v, 16'h0364);
        repeat (3) tick();
        check16("tx idle after reset", {15'd0, tx}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
